// File: rtl/csr_trap_ctrl.sv
// Sequencer/arbiter for the machine-mode CSR file's single port: CSR instruction
// read-modify-write, trap entry and mret, with PC redirect generation.
module csr_trap_ctrl #(
  parameter bit ILLEGAL_RO_WRITE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [1:0]  instr_op,
  input  logic [11:0] instr_addr,
  input  logic [31:0] instr_wdata,
  input  logic        instr_we,
  output logic        instr_ready,
  output logic [31:0] instr_rdata,
  output logic        instr_illegal,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  output logic        trap_ready,
  input  logic        mret_valid,
  output logic        mret_ready,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        csr_write_en,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_in,
  input  logic [31:0] csr_out
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  typedef enum logic [2:0] {
    S_IDLE, S_INSTR, S_T_EPC, S_T_CAUSE, S_T_STATUS, S_T_VEC, S_R_STATUS, S_R_EPC
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_op;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_cause;
  logic [31:0] r_pc;

  logic        w_addr_legal;
  logic        w_ro_write;
  logic        w_illegal;
  logic [31:0] w_rmw;
  logic [31:0] w_status_trap;
  logic [31:0] w_status_mret;
  logic [31:0] w_mtvec_base;
  logic [31:0] w_vec_pc;
  logic        w_vectored;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_op    <= 2'b00;
      r_addr  <= 12'h000;
      r_wdata <= 32'h0;
      r_we    <= 1'b0;
      r_cause <= 32'h0;
      r_pc    <= 32'h0;
    end else begin
      r_state <= w_state_next;
      // Latch only the winning requester so later input changes are ignored.
      if (r_state == S_IDLE) begin
        if (trap_valid) begin
          r_cause <= trap_cause;
          r_pc    <= trap_pc;
        end else if (!mret_valid && instr_valid) begin
          r_op    <= instr_op;
          r_addr  <= instr_addr;
          r_wdata <= instr_wdata;
          r_we    <= instr_we;
        end
      end
    end
  end

  always_comb begin
    unique case (r_addr)
      ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH,
      ADDR_MEPC, ADDR_MCAUSE, ADDR_MHARTID: w_addr_legal = 1'b1;
      default:                              w_addr_legal = 1'b0;
    endcase
  end

  assign w_ro_write = ILLEGAL_RO_WRITE && r_we && (r_addr[11:10] == 2'b11);
  assign w_illegal  = !w_addr_legal || (r_op == 2'b00) || w_ro_write;

  always_comb begin
    case (r_op)
      2'b10:   w_rmw = csr_out | r_wdata;
      2'b11:   w_rmw = csr_out & ~r_wdata;
      default: w_rmw = r_wdata;
    endcase
  end

  always_comb begin
    w_status_trap         = csr_out;
    w_status_trap[7]      = csr_out[3];
    w_status_trap[3]      = 1'b0;
    w_status_trap[12:11]  = 2'b11;
    w_status_mret         = csr_out;
    w_status_mret[3]      = csr_out[7];
    w_status_mret[7]      = 1'b1;
    w_status_mret[12:11]  = 2'b11;
  end

  // Vectored mode only applies to interrupts; 4*cause wraps modulo 2^32.
  assign w_mtvec_base = {csr_out[31:2], 2'b00};
  assign w_vec_pc     = w_mtvec_base + {r_cause[29:0], 2'b00};
  assign w_vectored   = (csr_out[1:0] == 2'b01) && r_cause[31];

  assign busy = (r_state != S_IDLE);

  always_comb begin
    w_state_next   = r_state;
    csr_write_en   = 1'b0;
    csr_addr       = 12'h000;
    csr_in         = 32'h0;
    instr_ready    = 1'b0;
    instr_rdata    = 32'h0;
    instr_illegal  = 1'b0;
    trap_ready     = 1'b0;
    mret_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (trap_valid)       w_state_next = S_T_EPC;
        else if (mret_valid)  w_state_next = S_R_STATUS;
        else if (instr_valid) w_state_next = S_INSTR;
      end
      S_INSTR: begin
        csr_addr      = r_addr;
        instr_ready   = 1'b1;
        instr_illegal = w_illegal;
        instr_rdata   = w_illegal ? 32'h0 : csr_out;
        if (r_we && !w_illegal) begin
          csr_write_en = 1'b1;
          csr_in       = w_rmw;
        end
        w_state_next = S_IDLE;
      end
      S_T_EPC: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MEPC;
        csr_in       = {r_pc[31:2], 2'b00};
        w_state_next = S_T_CAUSE;
      end
      S_T_CAUSE: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MCAUSE;
        csr_in       = r_cause;
        w_state_next = S_T_STATUS;
      end
      S_T_STATUS: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MSTATUS;
        csr_in       = w_status_trap;
        w_state_next = S_T_VEC;
      end
      S_T_VEC: begin
        csr_addr       = ADDR_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = w_vectored ? w_vec_pc : w_mtvec_base;
        trap_ready     = 1'b1;
        w_state_next   = S_IDLE;
      end
      S_R_STATUS: begin
        csr_write_en = 1'b1;
        csr_addr     = ADDR_MSTATUS;
        csr_in       = w_status_mret;
        w_state_next = S_R_EPC;
      end
      S_R_EPC: begin
        csr_addr       = ADDR_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = csr_out;
        mret_ready     = 1'b1;
        w_state_next   = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Self-checking bench for csr_trap_ctrl: behavioural CSR file plus a queue of
// expected completions compared as each ready pulse appears.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [1:0]  instr_op;
  logic [11:0] instr_addr;
  logic [31:0] instr_wdata;
  logic        instr_we;
  logic        instr_ready;
  logic [31:0] instr_rdata;
  logic        instr_illegal;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        trap_ready;
  logic        mret_valid;
  logic        mret_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        csr_write_en;
  logic [11:0] csr_addr;
  logic [31:0] csr_in;
  logic [31:0] csr_out;

  always #5 clk = ~clk;

  csr_trap_ctrl #(.ILLEGAL_RO_WRITE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_op(instr_op), .instr_addr(instr_addr),
    .instr_wdata(instr_wdata), .instr_we(instr_we), .instr_ready(instr_ready),
    .instr_rdata(instr_rdata), .instr_illegal(instr_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_ready(trap_ready), .mret_valid(mret_valid), .mret_ready(mret_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy),
    .csr_write_en(csr_write_en), .csr_addr(csr_addr), .csr_in(csr_in),
    .csr_out(csr_out)
  );

  // Behavioural CSR file: combinational read, write at the rising edge.
  logic [31:0] csr_mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [31:0] pl_data;

  assign csr_out = csr_mem[csr_addr];

  always @(posedge clk) begin
    if (csr_write_en) csr_mem[csr_addr] <= csr_in;
    else if (pl_en)   csr_mem[pl_addr] <= pl_data;
  end

  localparam logic [1:0] K_NONE = 2'd0, K_INSTR = 2'd1, K_TRAP = 2'd2, K_MRET = 2'd3;
  localparam logic [31:0] MHARTID = 32'h0000_0005;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] rdata;
    logic        illegal;
    logic [31:0] rpc;
    logic [7:0]  lat;
  } txn_t;

  txn_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic send_instr(input logic [1:0] op, input logic [11:0] a,
                            input logic [31:0] d, input logic we);
    instr_op = op; instr_addr = a; instr_wdata = d; instr_we = we; instr_valid = 1'b1;
  endtask

  task automatic send_trap(input logic [31:0] cause, input logic [31:0] pc);
    trap_cause = cause; trap_pc = pc; trap_valid = 1'b1;
  endtask

  // Waits (bounded) for the next completion pulse, captures what the DUT shows,
  // then drops that requester's valid just after the edge that ends the pulse.
  task automatic wait_done(output txn_t o);
    o = '0;
    for (int c = 1; c <= 20 && o.kind == K_NONE; c++) begin
      @(posedge clk); @(negedge clk);
      if (instr_ready || trap_ready || mret_ready) begin
        o.lat = 8'(c);
        if (trap_ready) begin
          o.kind = K_TRAP;
          o.rpc  = redirect_valid ? redirect_pc : 32'hBAD0_BAD0;
        end else if (mret_ready) begin
          o.kind = K_MRET;
          o.rpc  = redirect_valid ? redirect_pc : 32'hBAD0_BAD0;
        end else begin
          o.kind    = K_INSTR;
          o.rdata   = instr_rdata;
          o.illegal = instr_illegal;
        end
      end
    end
    @(posedge clk); #1;
    case (o.kind)
      K_TRAP:  trap_valid  = 1'b0;
      K_MRET:  mret_valid  = 1'b0;
      K_INSTR: instr_valid = 1'b0;
      default: begin trap_valid = 1'b0; mret_valid = 1'b0; instr_valid = 1'b0; end
    endcase
  endtask

  task automatic test_reset;
    logic [179:0] outs;
    rst = 1'b0;
    #1;
    outs = {busy, csr_write_en, csr_addr, csr_in, redirect_valid, redirect_pc,
            instr_ready, instr_rdata, instr_illegal, trap_ready, mret_ready};
    n_tests++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", outs);
    end
    trap_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold_busy got %b want 0", busy);
    end
    trap_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    $display("[TB] reset: busy=%b", busy);
  endtask

  task automatic test_rmw;
    txn_t o, e;
    preload(12'h340, 32'h0000_00F0);
    exp_q.push_back('{K_INSTR, 32'h0000_00F0, 1'b0, 32'h0, 8'd1});
    send_instr(2'b10, 12'h340, 32'h0000_000F, 1'b1);
    wait_done(o); e = exp_q.pop_front();
    $display("[TB] instr RS 0x340: rdata=%h illegal=%b lat=%0d", o.rdata, o.illegal, o.lat);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rmw_rs txn got %h want %h", o, e); end
    n_tests++;
    if (csr_mem[12'h340] !== 32'h0000_00FF) begin
      n_fail++; $display("FAIL rmw_rs_mem got %h want 000000ff", csr_mem[12'h340]);
    end
    exp_q.push_back('{K_INSTR, 32'h0000_00FF, 1'b0, 32'h0, 8'd1});
    send_instr(2'b11, 12'h340, 32'h0000_00F0, 1'b1);
    wait_done(o); e = exp_q.pop_front();
    $display("[TB] instr RC 0x340: rdata=%h illegal=%b lat=%0d", o.rdata, o.illegal, o.lat);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rmw_rc txn got %h want %h", o, e); end
    n_tests++;
    if (csr_mem[12'h340] !== 32'h0000_000F) begin
      n_fail++; $display("FAIL rmw_rc_mem got %h want 0000000f", csr_mem[12'h340]);
    end
    exp_q.push_back('{K_INSTR, 32'h0000_000F, 1'b0, 32'h0, 8'd1});
    send_instr(2'b01, 12'h340, 32'hCAFE_0001, 1'b1);
    wait_done(o); e = exp_q.pop_front();
    $display("[TB] instr RW 0x340: rdata=%h illegal=%b lat=%0d", o.rdata, o.illegal, o.lat);
    n_tests++;
    if (o !== e || csr_mem[12'h340] !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL rmw_rw got %h mem %h want %h mem cafe0001", o, csr_mem[12'h340], e);
    end
  endtask

  task automatic test_illegal;
    txn_t o, e;
    preload(12'h7C0, 32'h1111_1111);
    preload(12'hF14, MHARTID);
    exp_q.push_back('{K_INSTR, 32'h0, 1'b1, 32'h0, 8'd1});
    send_instr(2'b01, 12'h7C0, 32'hDEAD_BEEF, 1'b1);
    wait_done(o); e = exp_q.pop_front();
    $display("[TB] instr RW 0x7C0: rdata=%h illegal=%b", o.rdata, o.illegal);
    n_tests++;
    if (o !== e || csr_mem[12'h7C0] !== 32'h1111_1111) begin
      n_fail++; $display("FAIL illegal_addr got %h mem %h want %h mem 11111111", o, csr_mem[12'h7C0], e);
    end
    exp_q.push_back('{K_INSTR, 32'h0, 1'b1, 32'h0, 8'd1});
    send_instr(2'b01, 12'hF14, 32'h0000_0099, 1'b1);
    wait_done(o); e = exp_q.pop_front();
    $display("[TB] instr RW 0xF14 we=1: rdata=%h illegal=%b", o.rdata, o.illegal);
    n_tests++;
    if (o !== e || csr_mem[12'hF14] !== MHARTID) begin
      n_fail++; $display("FAIL illegal_ro_write got %h mem %h want %h mem %h", o, csr_mem[12'hF14], e, MHARTID);
    end
    exp_q.push_back('{K_INSTR, MHARTID, 1'b0, 32'h0, 8'd1});
    send_instr(2'b10, 12'hF14, 32'h0000_0000, 1'b0);
    wait_done(o); e = exp_q.pop_front();
    $display("[TB] instr RS 0xF14 we=0: rdata=%h illegal=%b", o.rdata, o.illegal);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL ro_read got %h want %h", o, e); end
    exp_q.push_back('{K_INSTR, 32'h0, 1'b1, 32'h0, 8'd1});
    send_instr(2'b00, 12'h340, 32'h5555_5555, 1'b1);
    wait_done(o); e = exp_q.pop_front();
    $display("[TB] instr op=00 0x340: rdata=%h illegal=%b", o.rdata, o.illegal);
    n_tests++;
    if (o !== e || csr_mem[12'h340] !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL illegal_op got %h mem %h want %h mem cafe0001", o, csr_mem[12'h340], e);
    end
  endtask

  task automatic test_trap;
    txn_t o, e;
    preload(12'h305, 32'h8000_0100);
    preload(12'h300, 32'h0000_0008);
    exp_q.push_back('{K_TRAP, 32'h0, 1'b0, 32'h8000_0100, 8'd4});
    send_trap(32'h0000_0002, 32'h0000_1236);
    wait_done(o); e = exp_q.pop_front();
    $display("[TB] trap direct: redirect=%h lat=%0d", o.rpc, o.lat);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL trap_direct txn got %h want %h", o, e); end
    n_tests++;
    if ({csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]} !== {32'h1234, 32'h2, 32'h1880}) begin
      n_fail++; $display("FAIL trap_direct_csrs got mepc %h mcause %h mstatus %h want 1234 2 1880",
                         csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]);
    end
    preload(12'h305, 32'h8000_0101);
    exp_q.push_back('{K_TRAP, 32'h0, 1'b0, 32'h8000_011C, 8'd4});
    send_trap(32'h8000_0007, 32'h0000_4000);
    wait_done(o); e = exp_q.pop_front();
    $display("[TB] trap vectored irq: redirect=%h lat=%0d", o.rpc, o.lat);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL trap_vectored txn got %h want %h", o, e); end
    exp_q.push_back('{K_TRAP, 32'h0, 1'b0, 32'h8000_0100, 8'd4});
    send_trap(32'h0000_0003, 32'h0000_5000);
    wait_done(o); e = exp_q.pop_front();
    $display("[TB] trap vectored exc: redirect=%h lat=%0d", o.rpc, o.lat);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL trap_vec_exception txn got %h want %h", o, e); end
  endtask

  task automatic test_mret;
    txn_t o, e;
    preload(12'h300, 32'h0000_1880);
    preload(12'h341, 32'h0000_1234);
    exp_q.push_back('{K_MRET, 32'h0, 1'b0, 32'h0000_1234, 8'd2});
    mret_valid = 1'b1;
    wait_done(o); e = exp_q.pop_front();
    $display("[TB] mret: redirect=%h lat=%0d mstatus=%h", o.rpc, o.lat, csr_mem[12'h300]);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL mret txn got %h want %h", o, e); end
    n_tests++;
    if (csr_mem[12'h300] !== 32'h0000_1888) begin
      n_fail++; $display("FAIL mret_mstatus got %h want 00001888", csr_mem[12'h300]);
    end
  endtask

  task automatic test_back_to_back;
    txn_t o, e;
    preload(12'h305, 32'h8000_0100);
    preload(12'h300, 32'h0000_0008);
    preload(12'h340, 32'h0000_ABCD);
    exp_q.push_back('{K_TRAP,  32'h0,        1'b0, 32'h8000_0100, 8'd4});
    exp_q.push_back('{K_MRET,  32'h0,        1'b0, 32'h0000_1234, 8'd2});
    exp_q.push_back('{K_INSTR, 32'h0000_ABCD, 1'b0, 32'h0,        8'd1});
    send_trap(32'h0000_0002, 32'h0000_1236);
    mret_valid = 1'b1;
    send_instr(2'b10, 12'h340, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_done(o); e = exp_q.pop_front();
      $display("[TB] back_to_back #%0d: kind=%0d lat=%0d rpc=%h rdata=%h", k, o.kind, o.lat, o.rpc, o.rdata);
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_order_%0d txn got %h want %h", k, o, e); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_%0d busy got %b want 0", k, busy); end
    end
    n_tests++;
    if (csr_mem[12'h300] !== 32'h0000_1888) begin
      n_fail++; $display("FAIL b2b_mstatus got %h want 00001888", csr_mem[12'h300]);
    end
  endtask

  task automatic test_reset_mid;
    logic [179:0] outs;
    logic         saw_redirect;
    preload(12'h341, 32'h0);
    preload(12'h342, 32'h0);
    preload(12'h300, 32'h0000_0008);
    preload(12'h305, 32'h8000_0100);
    send_trap(32'h0000_0005, 32'h0000_2002);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, csr_addr} !== {1'b1, 12'h300}) begin
      n_fail++; $display("FAIL mid_in_status got busy %b addr %h want 1 300", busy, csr_addr);
    end
    rst = 1'b0;
    #1;
    outs = {busy, csr_write_en, csr_addr, csr_in, redirect_valid, redirect_pc,
            instr_ready, instr_rdata, instr_illegal, trap_ready, mret_ready};
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL mid_reset_outputs got %h want 0", outs); end
    trap_valid = 1'b0;
    saw_redirect = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) rst = 1'b1;
      @(negedge clk);
      if (redirect_valid || trap_ready) saw_redirect = 1'b1;
      @(posedge clk); #1;
    end
    $display("[TB] reset mid-trap: mepc=%h mcause=%h mstatus=%h redirect_seen=%b",
             csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300], saw_redirect);
    n_tests++;
    if ({csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]} !== {32'h2000, 32'h5, 32'h8}) begin
      n_fail++; $display("FAIL mid_reset_csrs got mepc %h mcause %h mstatus %h want 2000 5 8",
                         csr_mem[12'h341], csr_mem[12'h342], csr_mem[12'h300]);
    end
    n_tests++;
    if ({saw_redirect, busy} !== 2'b00) begin
      n_fail++; $display("FAIL mid_reset_redirect got redirect %b busy %b want 0 0", saw_redirect, busy);
    end
  endtask

  initial begin
    rst = 1'b0;
    instr_valid = 1'b0; instr_op = 2'b00; instr_addr = 12'h0; instr_wdata = 32'h0; instr_we = 1'b0;
    trap_valid = 1'b0; trap_cause = 32'h0; trap_pc = 32'h0; mret_valid = 1'b0;
    pl_en = 1'b0; pl_addr = 12'h0; pl_data = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_rmw();
    test_illegal();
    test_trap();
    test_mret();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
